// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one instruction-bus request at a time,
// presents the returned word to the IF/ID register, and handles redirects
// by discarding responses to requests that became stale.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NOP
`define NOP 32'h00000013
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef NOSTOP
`define NOSTOP 1'b0
`endif

module if_fetch #(
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int                     MIN_LAT  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [5:0]             stall_i,
  input  logic                   jump_flag_i,
  input  logic [`ADDR_WIDTH-1:0] jump_addr_i,
  output logic                   ibus_req_o,
  output logic [`ADDR_WIDTH-1:0] ibus_addr_o,
  input  logic                   ibus_gnt_i,
  input  logic                   ibus_rvalid_i,
  input  logic [`DATA_WIDTH-1:0] ibus_rdata_i,
  output logic [`ADDR_WIDTH-1:0] inst_addr_o,
  output logic [`DATA_WIDTH-1:0] inst_o,
  output logic                   stallreq_o
);

  localparam int AW = `ADDR_WIDTH;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  localparam logic [AW-1:0] PC_STEP = AW'(4);

  logic [1:0]             state;
  logic                   kill;
  logic [AW-1:0]          pc;
  logic [`DATA_WIDTH-1:0] inst_q;
  logic [AW-1:0]          inst_addr_q;
  logic [AW-1:0]          jump_target;

  // Only stall bit 0 and the word-aligned part of the jump target matter here;
  // MIN_LAT describes the bus and has no influence on this logic.
  logic unused_bits;
  assign unused_bits = ^{stall_i[5:1], jump_addr_i[1:0], MIN_LAT[0]};

  assign jump_target = {jump_addr_i[AW-1:2], 2'b00};

  // Bus and stall-request outputs are decoded directly from the state.
  always_comb begin
    ibus_req_o  = (state == FETCH);
    ibus_addr_o = pc;
    stallreq_o  = (state != READY);
    inst_o      = inst_q;
    inst_addr_o = inst_addr_q;
  end

  // Fetch state machine, pc and the presented-instruction registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= FETCH;
      kill        <= 1'b0;
      pc          <= RESET_PC;
      inst_q      <= `NOP;
      inst_addr_q <= '0;
    end else if (jump_flag_i) begin
      pc          <= jump_target;
      inst_q      <= `NOP;
      inst_addr_q <= '0;
      case (state)
        FETCH: begin
          // A request granted on the redirect cycle fetched the old path.
          if (ibus_gnt_i) begin
            state <= WAIT;
            kill  <= 1'b1;
          end
        end
        WAIT: begin
          if (ibus_rvalid_i) begin
            state <= FETCH;
            kill  <= 1'b0;
          end else begin
            kill  <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (ibus_gnt_i) state <= WAIT;
        end
        WAIT: begin
          if (ibus_rvalid_i) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= FETCH;
            end else begin
              inst_q      <= ibus_rdata_i;
              inst_addr_q <= pc;
              state       <= READY;
            end
          end
        end
        READY: begin
          if (stall_i[0] == `NOSTOP) begin
            pc          <= pc + PC_STEP;
            inst_q      <= `NOP;
            inst_addr_q <= '0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by a random
// phase, all compared against a transaction-level reference model.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NOP
`define NOP 32'h00000013
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef NOSTOP
`define NOSTOP 1'b0
`endif

module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MIN_LAT  = 1;
  localparam logic [31:0] NOPW     = `NOP;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        stallreq;

  if_fetch #(.RESET_PC(RESET_PC), .MIN_LAT(MIN_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .ibus_req_o   (ibus_req),
    .ibus_addr_o  (ibus_addr),
    .ibus_gnt_i   (ibus_gnt),
    .ibus_rvalid_i(ibus_rvalid),
    .ibus_rdata_i (ibus_rdata),
    .inst_addr_o  (inst_addr),
    .inst_o       (inst),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Reference model in transaction terms: next fetch address, whether a
  // granted request is outstanding (and whether its answer is unwanted),
  // and whether an instruction is currently being offered downstream.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic        m_pending = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_have = 1'b0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_iaddr = '0;

  // Bus responder: one transaction, answered a number of cycles after grant.
  logic        bus_busy = 1'b0;
  int unsigned bus_left = 0;
  int unsigned bus_lat  = MIN_LAT;  // 0 selects a random latency per grant

  function automatic logic m_req();
    return !m_pending && !m_have;
  endfunction

  task automatic check_all();
    if (!m_valid) return;
    check_eq("req", 32'(ibus_req), 32'(m_req()));
    if (m_req()) check_eq("addr", ibus_addr, m_pc);
    check_eq("stallreq", 32'(stallreq), 32'(!m_have));
    check_eq("inst", inst, m_have ? m_inst : NOPW);
    check_eq("inst_addr", inst_addr, m_have ? m_iaddr : 32'h0);
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance model at the edge.
  task automatic cyc(input logic r, input logic j, input logic [31:0] ja,
                     input logic s, input logic g, input logic sp,
                     input logic [31:0] rd);
    logic ge;
    logic rv;
    rst         = r;
    jump_flag   = j;
    jump_addr   = ja;
    stall       = {5'($urandom), s};
    ibus_gnt    = g;
    ibus_rvalid = bus_busy ? (bus_left == 0) : sp;
    ibus_rdata  = rd;
    @(negedge clk);
    check_all();
    @(posedge clk);
    ge = m_req() && g;
    rv = ibus_rvalid;
    if (r) begin
      m_valid = 1'b1; m_pc = RESET_PC; m_pending = 1'b0; m_stale = 1'b0; m_have = 1'b0;
    end else if (j) begin
      m_pc = ja & ~32'h3;
      m_have = 1'b0;
      if (ge) begin
        m_pending = 1'b1; m_stale = 1'b1;
      end else if (m_pending) begin
        if (rv) begin m_pending = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
    end else if (m_have) begin
      if (s == `NOSTOP) begin m_have = 1'b0; m_pc = m_pc + 32'd4; end
    end else if (m_pending) begin
      if (rv) begin
        m_pending = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else begin m_have = 1'b1; m_inst = rd; m_iaddr = m_pc; end
      end
    end else if (ge) begin
      m_pending = 1'b1;
    end
    if (r) bus_busy = 1'b0;
    else if (bus_busy) begin
      if (rv) bus_busy = 1'b0;
      else bus_left--;
    end else if (ge) begin
      bus_busy = 1'b1;
      bus_left = ((bus_lat == 0) ? $urandom_range(MIN_LAT, MIN_LAT + 3) : bus_lat) - 1;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = '0; jump_flag = 1'b0; jump_addr = '0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
    @(posedge clk); #1;

    // Reset, then grant in cycle 1 and a response in cycle 2.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_eq("rst_req", 32'(ibus_req), 32'h1);
    check_eq("rst_addr", ibus_addr, RESET_PC);
    check_eq("rst_stallreq", 32'(stallreq), 32'h1);
    check_eq("rst_inst", inst, NOPW);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0000_0013);
    check_eq("first_inst", inst, 32'h0000_0013);
    check_eq("first_iaddr", inst_addr, 32'h0);
    check_eq("first_stallreq", 32'(stallreq), 32'h0);

    // Five stalled cycles in READY hold everything.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, `STOP, 1, 0, 32'hBAD0_0000);
      check_eq("stall_inst", inst, 32'h0000_0013);
      check_eq("stall_iaddr", inst_addr, 32'h0);
      check_eq("stall_req", 32'(ibus_req), 32'h0);
    end
    cyc(0, 0, 0, `NOSTOP, 0, 0, 0);
    check_eq("release_req", 32'(ibus_req), 32'h1);
    check_eq("release_addr", ibus_addr, 32'h4);

    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h1111_1111);
    check_eq("second_iaddr", inst_addr, 32'h4);
    cyc(0, 0, 0, `NOSTOP, 0, 0, 0);
    check_eq("third_addr", ibus_addr, 32'h8);

    // Redirect while waiting on the 0x8 response.
    bus_lat = 3;
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h100, 0, 0, 0, 0);
    check_eq("kill_stallreq", 32'(stallreq), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h2222_2222);
    check_eq("kill_inst", inst, NOPW);
    check_eq("kill_req", 32'(ibus_req), 32'h1);
    check_eq("kill_addr", ibus_addr, 32'h100);

    // Redirect on the grant cycle: the granted request is stale.
    bus_lat = 1;
    cyc(0, 1, 32'h41, 0, 1, 0, 0);
    check_eq("jg_req", 32'(ibus_req), 32'h0);
    check_eq("jg_stallreq", 32'(stallreq), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    check_eq("jg_inst", inst, NOPW);
    check_eq("jg_addr", ibus_addr, 32'h40);

    // pc wraps from the top word to 0.
    cyc(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    check_eq("top_addr", ibus_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h3333_3333);
    check_eq("top_iaddr", inst_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, `NOSTOP, 0, 0, 0);
    check_eq("wrap_addr", ibus_addr, 32'h0);

    // Reset while waiting, then reset while presenting.
    bus_lat = 3;
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_eq("rstw_addr", ibus_addr, RESET_PC);
    check_eq("rstw_inst", inst, NOPW);
    check_eq("rstw_stallreq", 32'(stallreq), 32'h1);
    bus_lat = 1;
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h4444_4444);
    cyc(1, 0, 0, `STOP, 0, 0, 0);
    check_eq("rstr_addr", ibus_addr, RESET_PC);
    check_eq("rstr_inst", inst, NOPW);
    check_eq("rstr_stallreq", 32'(stallreq), 32'h1);

    // Random traffic against the model.
    bus_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 19) == 0),
          ja,
          ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 9) == 0),
          $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL take parameter RESET_PC, default 0, as the first fetch address after reset.
REQ-002 SHALL take parameter MIN_LAT, default 1, as the minimum number of cycles from bus grant to bus response; the bench uses it, the RTL must not depend on it.
REQ-003 clk_i  in  1  single clock; all state updates on posedge clk_i.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 stall_i  in  6  pipeline stall vector from ctrl; bit 0 (`STOP/`NOSTOP) stalls this fetch stage.
REQ-006 jump_flag_i  in  1  redirect request from execute.
REQ-007 jump_addr_i  in  `ADDR_WIDTH  redirect target.
REQ-008 ibus_req_o  out  1  instruction bus request.
REQ-009 ibus_addr_o  out  `ADDR_WIDTH  instruction bus address.
REQ-010 ibus_gnt_i  in  1  bus accepts the request in this cycle.
REQ-011 ibus_rvalid_i  in  1  read data valid.
REQ-012 ibus_rdata_i  in  `DATA_WIDTH  read data.
REQ-013 inst_addr_o  out  `ADDR_WIDTH  address of the presented instruction, feeding the IF/ID register.
REQ-014 inst_o  out  `DATA_WIDTH  presented instruction, or `NOP.
REQ-015 stallreq_o  out  1  requests ctrl to stall fetch while no instruction is available.

Function
REQ-016 SHALL implement states FETCH, WAIT and READY, with a 1-bit kill flag and a pc register.
REQ-017 FETCH: ibus_req_o=1 and ibus_addr_o=pc. On ibus_gnt_i=1 the next state SHALL be WAIT; otherwise the block stays in FETCH.
REQ-018 ibus_req_o SHALL be 0 in WAIT and READY, so at most one request is outstanding.
REQ-019 WAIT, kill=0, ibus_rvalid_i=1: inst_o<=ibus_rdata_i, inst_addr_o<=pc, next state READY.
REQ-020 WAIT, kill=1, ibus_rvalid_i=1: the response SHALL be discarded, kill<=0, next state FETCH.
REQ-021 READY with stall_i[0]==`NOSTOP: pc<=pc+4, inst_o<=`NOP, inst_addr_o<=0, next state FETCH. The IF/ID register samples the presented instruction on this same edge.
REQ-022 READY with stall_i[0]==`STOP: inst_o, inst_addr_o and pc SHALL hold, and the state stays READY for any stall duration.
REQ-023 stallreq_o SHALL be 1 in FETCH and WAIT and 0 in READY; it is decoded from state, with no extra cycle of latency.
REQ-024 inst_o SHALL equal `NOP and inst_addr_o SHALL equal 0 in every state except READY.
REQ-025 jump_flag_i=1 SHALL win over stall_i and over the bus response. pc<={jump_addr_i[ADDR_WIDTH-1:2],2'b00}, inst_o<=`NOP, inst_addr_o<=0.
REQ-026 On a jump, the next state SHALL be:
 - FETCH with ibus_gnt_i=0: FETCH.
 - FETCH with ibus_gnt_i=1: WAIT with kill<=1, because the granted request is stale.
 - WAIT with ibus_rvalid_i=0: WAIT with kill<=1.
 - WAIT with ibus_rvalid_i=1: FETCH.
 - READY: FETCH.
REQ-027 A jump in WAIT while kill=1 SHALL keep kill=1 and only update pc.
REQ-028 pc+4 SHALL wrap modulo 2^`ADDR_WIDTH with no error indication.
REQ-029 ibus_rvalid_i outside WAIT SHALL be ignored.

Reset
REQ-030 While rst_i=1 at a posedge: pc<=RESET_PC, state<=FETCH, kill<=0, inst_o<=`NOP, inst_addr_o<=0.
REQ-031 In the first cycle after reset: ibus_req_o=1, ibus_addr_o=RESET_PC, stallreq_o=1.
REQ-032 Reset asserted in WAIT SHALL abandon the outstanding transaction. The bench SHALL not return rvalid for a pre-reset request after the FETCH grant.

Verification
REQ-033 Bench SHALL cover these directed scenarios:
 - Reset, then grant in cycle 1 and rvalid with 0x00000013 in cycle 2 -> inst_o=0x00000013, inst_addr_o=0 in cycle 3, stallreq_o=0; next request address 0x4.
 - Hold stall_i[0]=`STOP for 5 cycles while READY -> inst_o, inst_addr_o and ibus_req_o=0 unchanged for 5 cycles; the fetch of pc+4 starts the cycle after the stall releases.
 - Grant at 0x8, then jump_flag_i=1 to 0x100 in WAIT before rvalid -> the 0x8 response is discarded (inst_o stays `NOP) and the next request address is 0x100.
 - jump_flag_i=1 coincident with ibus_gnt_i=1 in FETCH, target 0x41 -> state WAIT with kill=1; the response is dropped and the next request address is 0x40.
 - pc=2^`ADDR_WIDTH-4 consumed -> next ibus_addr_o=0.
 - rst_i=1 asserted in WAIT and in READY -> the following cycle shows ibus_addr_o=RESET_PC, inst_o=`NOP, stallreq_o=1.
